// File: rtl/ocbench_host_master.sv
// Host-side master for the operand/compute/result benchmark: loads operands,
// kicks the control unit, polls for completion and streams results back out.
module ocbench_host_master #(
    parameter int RD_LATENCY = 2,
    parameter int POLL_GAP   = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic        AVALON_CLK,
    input  logic        AVALON_RESET_N,
    input  logic        START,
    input  logic [8:0]  WORD_COUNT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    input  logic [31:0] OPND_DATA,
    input  logic        OPND_VALID,
    output logic        OPND_READY,
    output logic [31:0] RES_DATA,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [8:0]  TX_ADDRESS,
    output logic [3:0]  TX_BYTEENABLE,
    output logic        TX_CHIPSELECT,
    output logic        TX_WRITE,
    output logic [31:0] TX_WRITEDATA,
    output logic [8:0]  CU_ADDRESS,
    output logic [3:0]  CU_BYTEENABLE,
    output logic        CU_CHIPSELECT,
    output logic        CU_WRITE,
    output logic [31:0] CU_WRITEDATA,
    output logic        CU_READ,
    input  logic [31:0] CU_READDATA,
    output logic [8:0]  RX_ADDRESS,
    output logic        RX_READ,
    input  logic [31:0] RX_READDATA
);

    localparam int LAT = RD_LATENCY - 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, KICK, POLL, WAIT, DRAIN, FIN
    } state_t;

    state_t      state;
    logic [8:0]  n;
    logic [8:0]  k;
    logic [8:0]  popped;
    logic [31:0] polls;
    logic [15:0] gap;
    logic        issued;
    logic [2:0]  cu_pipe;
    logic [2:0]  rx_pipe;
    logic [2:0]  cnt;
    logic [2:0]  inflight;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [31:0] mem [4];

    logic        busy, done, error;
    logic        tx_we, cu_we, cu_re, rx_re;
    logic [8:0]  tx_addr, cu_addr, rx_addr;
    logic [31:0] tx_data, cu_data;

    logic push, pop, issue, valid;
    logic unused_ok;

    assign valid = (cnt != 3'd0);
    assign push  = rx_pipe[LAT];
    assign pop   = valid && RES_READY;
    // occupancy plus reads in flight must stay within the 4-entry FIFO
    assign issue = (state == DRAIN) && (k != n) &&
                   (({1'b0, cnt} + {1'b0, inflight}) < 4'd4);
    assign unused_ok = ^CU_READDATA[31:1];

    always_ff @(posedge AVALON_CLK or negedge AVALON_RESET_N) begin
        if (!AVALON_RESET_N) begin
            state    <= IDLE;
            n        <= '0;
            k        <= '0;
            popped   <= '0;
            polls    <= '0;
            gap      <= '0;
            issued   <= 1'b0;
            cu_pipe  <= '0;
            rx_pipe  <= '0;
            cnt      <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            tx_we    <= 1'b0;
            cu_we    <= 1'b0;
            cu_re    <= 1'b0;
            rx_re    <= 1'b0;
            tx_addr  <= '0;
            cu_addr  <= '0;
            rx_addr  <= '0;
            tx_data  <= '0;
            cu_data  <= '0;
        end else begin
            tx_we    <= 1'b0;
            cu_we    <= 1'b0;
            cu_re    <= 1'b0;
            rx_re    <= 1'b0;
            done     <= 1'b0;
            cu_pipe  <= {cu_pipe[1:0], cu_re};
            rx_pipe  <= {rx_pipe[1:0], rx_re};
            cnt      <= cnt + 3'(push) - 3'(pop);
            inflight <= inflight + 3'(issue) - 3'(push);
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
                popped <= popped + 9'd1;
            end
            unique case (state)
                IDLE: if (START) begin
                    error  <= 1'b0;
                    busy   <= 1'b1;
                    n      <= WORD_COUNT;
                    k      <= '0;
                    popped <= '0;
                    polls  <= '0;
                    state  <= (WORD_COUNT == 9'd0) ? FIN : LOAD;
                end
                LOAD: if (OPND_VALID) begin
                    tx_we   <= 1'b1;
                    tx_addr <= k;
                    tx_data <= OPND_DATA;
                    k       <= k + 9'd1;
                    if (k == n - 9'd1) state <= KICK;
                end
                KICK: begin
                    cu_we   <= 1'b1;
                    cu_addr <= 9'd0;
                    cu_data <= {22'b0, n, 1'b1};
                    issued  <= 1'b0;
                    state   <= POLL;
                end
                POLL: begin
                    if (!issued) begin
                        cu_re   <= 1'b1;
                        cu_addr <= 9'd1;
                        issued  <= 1'b1;
                        polls   <= polls + 32'd1;
                    end else if (cu_pipe[LAT]) begin
                        if (CU_READDATA[0]) begin
                            k     <= '0;
                            state <= DRAIN;
                        end else if (polls == 32'(TIMEOUT)) begin
                            error <= 1'b1;
                            state <= FIN;
                        end else begin
                            gap   <= '0;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (gap == 16'(POLL_GAP - 1)) begin
                        issued <= 1'b0;
                        state  <= POLL;
                    end else begin
                        gap <= gap + 16'd1;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        rx_re   <= 1'b1;
                        rx_addr <= k;
                        k       <= k + 9'd1;
                    end
                    if (pop && popped == n - 9'd1) state <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge AVALON_CLK) begin
        if (push) mem[wr_ptr] <= RX_READDATA;
    end

    assign BUSY          = busy;
    assign DONE          = done;
    assign ERROR         = error;
    assign OPND_READY    = (state == LOAD);
    assign RES_VALID     = valid;
    assign RES_DATA      = valid ? mem[rd_ptr] : 32'd0;
    assign TX_ADDRESS    = tx_addr;
    assign TX_WRITE      = tx_we;
    assign TX_CHIPSELECT = tx_we;
    assign TX_BYTEENABLE = {4{tx_we}};
    assign TX_WRITEDATA  = tx_data;
    assign CU_ADDRESS    = cu_addr;
    assign CU_WRITE      = cu_we;
    assign CU_READ       = cu_re;
    assign CU_CHIPSELECT = cu_we | cu_re;
    assign CU_BYTEENABLE = {4{cu_we | cu_re}};
    assign CU_WRITEDATA  = cu_data;
    assign RX_ADDRESS    = rx_addr;
    assign RX_READ       = rx_re;

endmodule

// File: tb/tb_ocbench_host_master.sv
// Scoreboard bench for ocbench_host_master with CU/RX slave models
// and a varying result-stream back-pressure.
module tb_ocbench_host_master;

    localparam int RDL = 2;

    logic        clk, rst_n;
    logic        START;
    logic [8:0]  WORD_COUNT;
    logic        BUSY, DONE, ERROR;
    logic [31:0] OPND_DATA;
    logic        OPND_VALID, OPND_READY;
    logic [31:0] RES_DATA;
    logic        RES_VALID, RES_READY;
    logic [8:0]  TX_ADDRESS;
    logic [3:0]  TX_BYTEENABLE;
    logic        TX_CHIPSELECT, TX_WRITE;
    logic [31:0] TX_WRITEDATA;
    logic [8:0]  CU_ADDRESS;
    logic [3:0]  CU_BYTEENABLE;
    logic        CU_CHIPSELECT, CU_WRITE, CU_READ;
    logic [31:0] CU_WRITEDATA, CU_READDATA;
    logic [8:0]  RX_ADDRESS;
    logic        RX_READ;
    logic [31:0] RX_READDATA;

    ocbench_host_master #(
        .RD_LATENCY(RDL),
        .POLL_GAP(4),
        .TIMEOUT(4)
    ) dut (
        .AVALON_CLK(clk),
        .AVALON_RESET_N(rst_n),
        .START(START),
        .WORD_COUNT(WORD_COUNT),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERROR(ERROR),
        .OPND_DATA(OPND_DATA),
        .OPND_VALID(OPND_VALID),
        .OPND_READY(OPND_READY),
        .RES_DATA(RES_DATA),
        .RES_VALID(RES_VALID),
        .RES_READY(RES_READY),
        .TX_ADDRESS(TX_ADDRESS),
        .TX_BYTEENABLE(TX_BYTEENABLE),
        .TX_CHIPSELECT(TX_CHIPSELECT),
        .TX_WRITE(TX_WRITE),
        .TX_WRITEDATA(TX_WRITEDATA),
        .CU_ADDRESS(CU_ADDRESS),
        .CU_BYTEENABLE(CU_BYTEENABLE),
        .CU_CHIPSELECT(CU_CHIPSELECT),
        .CU_WRITE(CU_WRITE),
        .CU_WRITEDATA(CU_WRITEDATA),
        .CU_READ(CU_READ),
        .CU_READDATA(CU_READDATA),
        .RX_ADDRESS(RX_ADDRESS),
        .RX_READ(RX_READ),
        .RX_READDATA(RX_READDATA)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] tx_q [$];
    logic [31:0] res_q [$];

    logic [8:0] cur_n;
    int done_at, rdy_mode, cyc;
    int tx_cnt, cu_wr_cnt, poll_seen, rx_cnt, rx_next, pops;
    int done_cnt, busy_cyc, viol, max_tx, max_rx;
    bit mon_on;

    logic        cu_v [4];
    logic [31:0] cu_d [4];
    logic        rx_v [4];
    logic [8:0]  rx_a [4];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rx_val(input logic [8:0] a);
        return {7'h35, a, 7'h00, a} ^ 32'h0000_9ABC;
    endfunction

    always @(negedge clk) begin
        int ns;
        cyc++;
        case (rdy_mode)
            0:       RES_READY = 1'b1;
            1:       RES_READY = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: RES_READY = 1'($urandom_range(0, 1));
        endcase
        for (int i = 3; i > 0; i--) begin
            cu_v[i] = cu_v[i-1];
            cu_d[i] = cu_d[i-1];
            rx_v[i] = rx_v[i-1];
            rx_a[i] = rx_a[i-1];
        end
        cu_v[0] = CU_READ;
        rx_v[0] = RX_READ;
        rx_a[0] = RX_ADDRESS;
        cu_d[0] = 32'hFFFF_FFFF;
        if (CU_READ) begin
            poll_seen++;
            cu_d[0] = (done_at != 0 && poll_seen >= done_at) ?
                      32'h5A5A_0001 : 32'h5A5A_0000;
        end
        CU_READDATA = cu_v[RDL] ? cu_d[RDL] : 32'hFFFF_FFFF;
        RX_READDATA = rx_v[RDL] ? rx_val(rx_a[RDL]) : 32'hBAD0_BAD0;

        if (mon_on) begin
            ns = int'(TX_WRITE) + int'(CU_WRITE) + int'(CU_READ) + int'(RX_READ);
            if (ns > 1) viol++;
            if (TX_CHIPSELECT !== TX_WRITE) viol++;
            if (TX_BYTEENABLE !== (TX_WRITE ? 4'hF : 4'h0)) viol++;
            if (CU_CHIPSELECT !== (CU_WRITE | CU_READ)) viol++;
            if (CU_BYTEENABLE !== ((CU_WRITE | CU_READ) ? 4'hF : 4'h0)) viol++;
            if (TX_WRITE) begin
                tx_cnt++;
                if (int'(TX_ADDRESS) > max_tx) max_tx = int'(TX_ADDRESS);
                if (tx_q.size() == 0) chk("tx_extra", 1, 0);
                else chk("tx_wr", {23'd0, TX_ADDRESS, TX_WRITEDATA}, tx_q.pop_front());
            end
            if (CU_WRITE) begin
                cu_wr_cnt++;
                chk("cu_wr", {CU_ADDRESS, CU_WRITEDATA}, {9'd0, 22'd0, cur_n, 1'b1});
            end
            if (CU_READ) chk("cu_rd_addr", CU_ADDRESS, 1);
            if (RX_READ) begin
                rx_cnt++;
                if (int'(RX_ADDRESS) > max_rx) max_rx = int'(RX_ADDRESS);
                chk("rx_addr", RX_ADDRESS, rx_next);
                rx_next++;
            end
            if (rx_cnt - pops > 4) viol++;
            if (RES_VALID && RES_READY) begin
                if (res_q.size() == 0) chk("res_extra", 1, 0);
                else chk("res", RES_DATA, res_q.pop_front());
                pops++;
            end
            if (DONE) done_cnt++;
            if (BUSY) busy_cyc++;
        end
    end

    task automatic zero_outs(input string tag);
        chk({tag, "_ctl"}, {BUSY, DONE, ERROR, OPND_READY, RES_VALID,
             TX_WRITE, TX_CHIPSELECT, CU_WRITE, CU_READ, CU_CHIPSELECT,
             RX_READ, TX_BYTEENABLE, CU_BYTEENABLE}, 0);
        chk({tag, "_dat"}, {RES_DATA, TX_WRITEDATA}, 0);
        chk({tag, "_cu"}, {CU_WRITEDATA, CU_ADDRESS, TX_ADDRESS, RX_ADDRESS}, 0);
    endtask

    task automatic clear_stats();
        tx_cnt = 0; cu_wr_cnt = 0; poll_seen = 0; rx_cnt = 0; rx_next = 0;
        pops = 0; done_cnt = 0; busy_cyc = 0; viol = 0; max_tx = 0; max_rx = 0;
        tx_q.delete();
        res_q.delete();
    endtask

    task automatic feed(input int n);
        int g;
        logic [31:0] d;
        for (int w = 0; w < n; w++) begin
            if ($urandom_range(0, 3) == 0) begin
                OPND_VALID = 1'b0;
                @(negedge clk);
            end
            d = {16'(2 * w + 2), 16'(2 * w + 1)};
            OPND_VALID = 1'b1;
            OPND_DATA  = d;
            g = 0;
            while (!OPND_READY && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!OPND_READY) begin
                chk("opnd_ready", 0, 1);
                break;
            end
            tx_q.push_back({23'd0, 9'(w), d});
            @(negedge clk);
        end
        OPND_VALID = 1'b0;
    endtask

    task automatic run(input int n, input int dat, input bit exp_err,
                       input int mode);
        int g, exp_polls;
        clear_stats();
        cur_n = 9'(n);
        done_at = dat;
        rdy_mode = mode;
        exp_polls = (n == 0) ? 0 : (exp_err ? 4 : dat);
        if (!exp_err)
            for (int a = 0; a < n; a++) res_q.push_back(rx_val(9'(a)));
        START = 1'b1;
        WORD_COUNT = 9'(n);
        @(negedge clk);
        START = 1'b0;
        chk("busy_on", BUSY, 1);
        chk("err_clr", ERROR, 0);
        feed(n);
        if (n > 0) begin
            START = 1'b1;
            WORD_COUNT = 9'd7;
            @(negedge clk);
            START = 1'b0;
        end
        g = 0;
        while (!DONE && g < 20000) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("done_seen", DONE, 1);
        chk("busy_off", BUSY, 0);
        chk("error", ERROR, exp_err);
        @(negedge clk);
        #1;
        chk("done_pulse", DONE, 0);
        chk("done_cnt", done_cnt, 1);
        chk("tx_cnt", tx_cnt, n);
        chk("cu_wr_cnt", cu_wr_cnt, (n > 0) ? 1 : 0);
        chk("polls", poll_seen, exp_polls);
        chk("rx_cnt", rx_cnt, exp_err ? 0 : n);
        chk("pops", pops, exp_err ? 0 : n);
        chk("res_left", res_q.size(), 0);
        chk("tx_left", tx_q.size(), 0);
        chk("proto", viol, 0);
        if (n == 0) chk("busy_cyc", busy_cyc, 1);
        if (n > 0) chk("max_tx", max_tx, n - 1);
        if (n > 0 && !exp_err) chk("max_rx", max_rx, n - 1);
    endtask

    task automatic reset_mid();
        int g;
        clear_stats();
        cur_n = 9'd4;
        done_at = 1;
        rdy_mode = 0;
        for (int a = 0; a < 4; a++) res_q.push_back(rx_val(9'(a)));
        START = 1'b1;
        WORD_COUNT = 9'd4;
        @(negedge clk);
        START = 1'b0;
        feed(4);
        g = 0;
        while (pops < 2 && g < 2000) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("rst_pops", pops, 2);
        chk("rst_busy", BUSY, 1);
        rst_n = 1'b0;
        #1;
        zero_outs("rst_now");
        mon_on = 1'b0;
        @(negedge clk);
        zero_outs("rst_hold");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_idle", {BUSY, RES_VALID, OPND_READY, DONE}, 0);
        res_q.delete();
        tx_q.delete();
        mon_on = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        START = 1'b0;
        WORD_COUNT = '0;
        OPND_VALID = 1'b0;
        OPND_DATA = '0;
        RES_READY = 1'b0;
        CU_READDATA = 32'hFFFF_FFFF;
        RX_READDATA = 32'hBAD0_BAD0;
        mon_on = 1'b0;
        cur_n = '0;
        done_at = 0;
        rdy_mode = 0;
        cyc = 0;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            cu_v[i] = 1'b0;
            cu_d[i] = '0;
            rx_v[i] = 1'b0;
            rx_a[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        zero_outs("por");
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);

        run(3, 2, 1'b0, 0);
        run(0, 1, 1'b0, 0);
        run(5, 0, 1'b1, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("err_sticky", ERROR, 1);
        run(8, 1, 1'b0, 1);
        reset_mid();
        run(2, 3, 1'b0, 2);
        run(511, 1, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
